// File: rtl/saes_round_engine.sv
// Iterative Simplified-AES engine: 16-bit block, NUM_ROUNDS rounds at one round per clock,
// with on-accept key expansion, optional decrypt datapath and valid/ready on both sides.
module saes_round_engine #(
    parameter int NUM_ROUNDS = 2,
    parameter bit DEC_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode,
    input  logic [15:0] data_in,
    input  logic [15:0] key_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] data_out,
    output logic        busy
);

    localparam int RW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    generate
        if (NUM_ROUNDS < 1 || NUM_ROUNDS > 8) begin : g_bad_rounds
            $error("saes_round_engine: NUM_ROUNDS must be within 1..8");
        end
    endgenerate

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h9;  4'h1: y = 4'h4;  4'h2: y = 4'hA;  4'h3: y = 4'hB;
            4'h4: y = 4'hD;  4'h5: y = 4'h1;  4'h6: y = 4'h8;  4'h7: y = 4'h5;
            4'h8: y = 4'h6;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'h3;
            4'hC: y = 4'hC;  4'hD: y = 4'hE;  4'hE: y = 4'hF;  default: y = 4'h7;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hA;  4'h1: y = 4'h5;  4'h2: y = 4'h9;  4'h3: y = 4'hB;
            4'h4: y = 4'h1;  4'h5: y = 4'h7;  4'h6: y = 4'h8;  4'h7: y = 4'hF;
            4'h8: y = 4'h6;  4'h9: y = 4'h0;  4'hA: y = 4'h2;  4'hB: y = 4'h3;
            4'hC: y = 4'hC;  4'hD: y = 4'h4;  4'hE: y = 4'hD;  default: y = 4'hE;
        endcase
        return y;
    endfunction

    function automatic logic [15:0] sub_nib16(input logic [15:0] x);
        return {sbox(x[15:12]), sbox(x[11:8]), sbox(x[7:4]), sbox(x[3:0])};
    endfunction

    function automatic logic [15:0] inv_sub_nib16(input logic [15:0] x);
        return {inv_sbox(x[15:12]), inv_sbox(x[11:8]), inv_sbox(x[7:4]), inv_sbox(x[3:0])};
    endfunction

    // Nibble swap of [11:8] and [3:0]; it is its own inverse.
    function automatic logic [15:0] shift_rows(input logic [15:0] x);
        return {x[15:12], x[3:0], x[7:4], x[11:8]};
    endfunction

    function automatic logic [3:0] xtime(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [3:0] mul4(input logic [3:0] a);
        return xtime(xtime(a));
    endfunction

    function automatic logic [3:0] mul9(input logic [3:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    // Columns are (x[15:12], x[11:8]) and (x[7:4], x[3:0]).
    function automatic logic [15:0] mix_col(input logic [15:0] x);
        return {x[15:12] ^ mul4(x[11:8]), mul4(x[15:12]) ^ x[11:8],
                x[7:4]   ^ mul4(x[3:0]),  mul4(x[7:4])   ^ x[3:0]};
    endfunction

    function automatic logic [15:0] inv_mix_col(input logic [15:0] x);
        return {mul9(x[15:12]) ^ xtime(x[11:8]), xtime(x[15:12]) ^ mul9(x[11:8]),
                mul9(x[7:4])   ^ xtime(x[3:0]),  xtime(x[7:4])   ^ mul9(x[3:0])};
    endfunction

    function automatic logic [7:0] rcon(input int i);
        logic [7:0] r;
        case (i)
            1: r = 8'h80;  2: r = 8'h30;  3: r = 8'h60;  4: r = 8'hC0;
            5: r = 8'hB0;  6: r = 8'h50;  7: r = 8'hA0;  8: r = 8'h70;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] sub_rot(input logic [7:0] w);
        return {sbox(w[3:0]), sbox(w[7:4])};
    endfunction

    state_t        state_q, state_d;
    logic [15:0]   st_q;
    logic [15:0]   data_out_q;
    logic [RW-1:0] round_q;
    logic          mode_q;
    logic [15:0]   rk_q    [0:NUM_ROUNDS];
    logic [15:0]   rk_next [0:NUM_ROUNDS];
    logic [7:0]    w       [0:2*NUM_ROUNDS+1];

    logic          accept;
    logic          mode_in;
    logic          last_round;
    logic [15:0]   k_enc, k_dec;
    logic [15:0]   enc_sr, enc_next;
    logic [15:0]   dec_pre, dec_next;
    logic [15:0]   round_next;
    logic [15:0]   whiten_key;

    assign accept     = in_valid & in_ready;
    assign mode_in    = DEC_EN & mode;
    assign last_round = (round_q == RW'(NUM_ROUNDS));

    // Full schedule is built combinationally from key_in so every round key is ready on accept.
    always_comb begin
        w[0] = key_in[15:8];
        w[1] = key_in[7:0];
        for (int i = 1; i <= NUM_ROUNDS; i++) begin
            w[2*i]   = w[2*i-2] ^ rcon(i) ^ sub_rot(w[2*i-1]);
            w[2*i+1] = w[2*i] ^ w[2*i-1];
        end
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            rk_next[i] = {w[2*i], w[2*i+1]};
        end
    end

    assign whiten_key = mode_in ? rk_next[NUM_ROUNDS] : rk_next[0];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        k_enc = 16'h0000;
        k_dec = 16'h0000;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (round_q == RW'(i))              k_enc = rk_q[i];
            if (round_q == RW'(NUM_ROUNDS - i)) k_dec = rk_q[i];
        end
    end

    assign enc_sr   = shift_rows(sub_nib16(st_q));
    assign enc_next = (last_round ? enc_sr : mix_col(enc_sr)) ^ k_enc;

    generate
        if (DEC_EN) begin : g_dec
            assign dec_pre  = inv_sub_nib16(shift_rows(st_q)) ^ k_dec;
            assign dec_next = last_round ? dec_pre : inv_mix_col(dec_pre);
        end else begin : g_no_dec
            assign dec_pre  = 16'h0000;
            assign dec_next = 16'h0000;
        end
    endgenerate

    assign round_next = mode_q ? dec_next : enc_next;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_round) state_d = DONE;
            DONE:    if (out_ready) state_d = in_valid ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN);
    end

    assign data_out = data_out_q;

    // NOTE: the round-key bank is reset as well, so no key material survives a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= 16'h0000;
            data_out_q <= 16'h0000;
            round_q    <= '0;
            mode_q     <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= 16'h0000;
        end else if (accept) begin
            st_q    <= data_in ^ whiten_key;
            round_q <= RW'(1);
            mode_q  <= mode_in;
            for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= rk_next[i];
        end else if (state_q == RUN) begin
            st_q <= round_next;
            if (last_round) begin
                data_out_q <= round_next;
                round_q    <= '0;
            end else begin
                round_q <= round_q + RW'(1);
            end
        end
    end

endmodule

// File: tb/tb_saes_round_engine.sv
// Bench for saes_round_engine: known S-AES vectors, handshake corner cases and a
// scoreboard-driven random stream on a 4-round instance against a behavioural model.
module tb_saes_round_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, mode, out_valid, out_ready, busy;
    logic [15:0] data_in, key_in, data_out;
    logic        in_valid_4, in_ready_4, mode_4, out_valid_4, out_ready_4, busy_4;
    logic [15:0] data_in_4, key_in_4, data_out_4;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q  [$];
    logic [15:0] exp_q4 [$];
    logic [15:0] pt [200];
    logic [15:0] kk [200];
    logic [15:0] ct [200];

    typedef struct {
        logic        m;
        logic [15:0] d;
        logic [15:0] k;
        logic [15:0] e;
    } vec_t;
    vec_t kv [4];

    saes_round_engine #(.NUM_ROUNDS(2), .DEC_EN(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .data_in(data_in), .key_in(key_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .busy(busy)
    );

    saes_round_engine #(.NUM_ROUNDS(4), .DEC_EN(1'b1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_4), .in_ready(in_ready_4), .mode(mode_4),
        .data_in(data_in_4), .key_in(key_in_4), .out_valid(out_valid_4), .out_ready(out_ready_4),
        .data_out(data_out_4), .busy(busy_4)
    );

    // ---------------- behavioural model ----------------
    localparam logic [63:0] SBOX_TAB = 64'h94AB_D185_6203_CEF7;

    function automatic logic [3:0] tb_sbox(input logic [3:0] x);
        return SBOX_TAB[63 - 4*int'(x) -: 4];
    endfunction

    function automatic logic [3:0] tb_inv_sbox(input logic [3:0] v);
        logic [3:0] r = 4'h0;
        for (int j = 0; j < 16; j++) if (tb_sbox(4'(j)) == v) r = 4'(j);
        return r;
    endfunction

    function automatic logic [3:0] tb_gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p = 4'h0;
        logic [3:0] aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[3] ? ({aa[2:0], 1'b0} ^ 4'b0011) : {aa[2:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [15:0] tb_round_key(input logic [15:0] key, input int idx);
        logic [7:0] w0 = key[15:8];
        logic [7:0] w1 = key[7:0];
        logic [3:0] rc;
        for (int i = 1; i <= idx; i++) begin
            rc = 4'h1;
            for (int j = 0; j < i + 2; j++) rc = tb_gmul(rc, 4'h2);
            w0 = w0 ^ {rc, 4'h0} ^ {tb_sbox(w1[3:0]), tb_sbox(w1[7:4])};
            w1 = w0 ^ w1;
        end
        return {w0, w1};
    endfunction

    function automatic logic [15:0] tb_enc(input logic [15:0] p, input logic [15:0] key, input int n);
        logic [15:0] s;
        logic [3:0]  nb [4];
        logic [3:0]  t;
        s = p ^ tb_round_key(key, 0);
        for (int r = 1; r <= n; r++) begin
            for (int j = 0; j < 4; j++) nb[j] = tb_sbox(s[15-4*j -: 4]);
            t = nb[1]; nb[1] = nb[3]; nb[3] = t;
            if (r < n)
                s = {nb[0] ^ tb_gmul(4'h4, nb[1]), tb_gmul(4'h4, nb[0]) ^ nb[1],
                     nb[2] ^ tb_gmul(4'h4, nb[3]), tb_gmul(4'h4, nb[2]) ^ nb[3]};
            else
                s = {nb[0], nb[1], nb[2], nb[3]};
            s = s ^ tb_round_key(key, r);
        end
        return s;
    endfunction

    // ---------------- drive / wait helpers (no comparisons) ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send2(input logic m, input logic [15:0] d, input logic [15:0] k,
                         input logic [15:0] e, output bit ok);
        ok = 1'b0;
        mode = m; data_in = d; key_in = k; in_valid = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (in_ready) begin
                exp_q.push_back(e);
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        mode = 1'($urandom); data_in = 16'($urandom); key_in = 16'($urandom);
    endtask

    task automatic wait_out2(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; mode = 1'b0; data_in = 16'h0; key_in = 16'h0; out_ready = 1'b1;
        in_valid_4 = 1'b0; mode_4 = 1'b0; data_in_4 = 16'h0; key_in_4 = 16'h0; out_ready_4 = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL reset_data_out got %h want 0000", data_out); end
        checks++; if (out_valid_4 !== 1'b0 || in_ready_4 !== 1'b1) begin
            errors++; $display("FAIL reset_dut4 got out_valid %b in_ready %b want 0 1", out_valid_4, in_ready_4);
        end
    endtask

    task automatic test_known_vectors();
        bit          ok;
        int          lat;
        logic [15:0] want;
        kv[0] = '{1'b0, 16'h6F6B, 16'hA73B, 16'h0738};
        kv[1] = '{1'b1, 16'h0738, 16'hA73B, 16'h6F6B};
        kv[2] = '{1'b0, 16'hD728, 16'h4AF5, 16'h24EC};
        kv[3] = '{1'b1, 16'h24EC, 16'h4AF5, 16'hD728};
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            send2(kv[v].m, kv[v].d, kv[v].k, kv[v].e, ok);
            checks++; if (!ok) begin errors++; $display("FAIL vec%0d_accept got 0 want 1", v); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL vec%0d_busy got %b want 1", v, busy); end
            wait_out2(lat);
            checks++; if (lat != 2) begin errors++; $display("FAIL vec%0d_latency got %0d want 2", v, lat); end
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checks++;
                if (data_out !== want) begin errors++; $display("FAIL vec%0d_data got %h want %h", v, data_out, want); end
            end
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_drop got %b want 0", v, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        bit          ok;
        int          lat;
        logic [15:0] want;
        out_ready = 1'b0;
        send2(1'b0, 16'hD728, 16'h4AF5, 16'h24EC, ok);
        wait_out2(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL bp_latency got %0d want 2", lat); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || data_out !== 16'h24EC || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b want v=1 d=24EC rdy=0", i, out_valid, data_out, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        mode = 1'b1; data_in = 16'h24EC; key_in = 16'h4AF5; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready got %b want 1", in_ready); end
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (data_out !== want) begin errors++; $display("FAIL bp_data got %h want %h", data_out, want); end
        end
        exp_q.push_back(16'hD728);
        @(posedge clk); #1;
        in_valid = 1'b0; data_in = 16'hFFFF; key_in = 16'h0000;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_bubble got busy=%b v=%b want busy=1 v=0", busy, out_valid);
        end
        wait_out2(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL bp2_latency got %0d want 2", lat); end
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (data_out !== want) begin errors++; $display("FAIL bp2_data got %h want %h", data_out, want); end
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        bit          ok;
        int          lat;
        int          seen = 0;
        logic [15:0] want;
        out_ready = 1'b1;
        send2(1'b0, 16'h6F6B, 16'hA73B, 16'h0738, ok);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || data_out !== 16'h0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_abort got busy=%b v=%b d=%h rdy=%b want 0 0 0000 1", busy, out_valid, data_out, in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_no_output got %0d want 0", seen); end
        send2(1'b1, 16'h0738, 16'hA73B, 16'h6F6B, ok);
        wait_out2(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL rst_after_latency got %0d want 2", lat); end
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (data_out !== want) begin errors++; $display("FAIL rst_after_data got %h want %h", data_out, want); end
        end
        tick();
    endtask

    task automatic test_run_ignores_inputs();
        bit          ok;
        logic [15:0] want;
        out_ready = 1'b1;
        send2(1'b0, 16'h6F6B, 16'hA73B, 16'h0738, ok);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; mode = 1'($urandom); data_in = 16'($urandom); key_in = 16'($urandom);
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL run_ignore%0d got rdy=%b busy=%b want 0 1", i, in_ready, busy);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL run_ignore_valid got %b want 1", out_valid); end
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (data_out !== want) begin errors++; $display("FAIL run_ignore_data got %h want %h", data_out, want); end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL run_ignore_idle got v=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic run_stream4(input bit dec);
        fork
            begin : driver
                int c;
                for (int i = 0; i < 200; i++) begin
                    mode_4 = dec; data_in_4 = dec ? ct[i] : pt[i]; key_in_4 = kk[i]; in_valid_4 = 1'b1;
                    #1;
                    c = 0;
                    while (!in_ready_4 && c < 50) begin
                        @(posedge clk); #2;
                        c++;
                    end
                    if (!in_ready_4) begin
                        checks++; errors++;
                        $display("FAIL stream_accept_timeout got block %0d want accepted", i);
                        break;
                    end
                    exp_q4.push_back(dec ? pt[i] : tb_enc(pt[i], kk[i], 4));
                    @(posedge clk); #1;
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid_4 = 1'b0; data_in_4 = 16'($urandom);
                        tick();
                    end
                end
                in_valid_4 = 1'b0;
            end
            begin : monitor
                int          n = 0;
                int          cyc = 0;
                logic [15:0] want;
                while (n < 200 && cyc < 6000) begin
                    out_ready_4 = ($urandom_range(0, 3) != 0);
                    #1;
                    if (out_valid_4 && out_ready_4 && exp_q4.size() > 0) begin
                        want = exp_q4.pop_front();
                        checks++;
                        if (data_out_4 !== want) begin
                            errors++;
                            $display("FAIL stream_%s%0d got %h want %h", dec ? "dec" : "enc", n, data_out_4, want);
                        end
                        if (!dec) ct[n] = data_out_4;
                        n++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                if (n < 200) begin
                    checks++; errors++;
                    $display("FAIL stream_timeout got %0d results want 200", n);
                end
            end
        join
        out_ready_4 = 1'b1;
    endtask

    task automatic test_rounds4_random();
        int          lat = -1;
        logic [15:0] want;
        out_ready_4 = 1'b1;
        mode_4 = 1'b0; data_in_4 = 16'h6F6B; key_in_4 = 16'hA73B; in_valid_4 = 1'b1;
        #1;
        checks++; if (in_ready_4 !== 1'b1) begin errors++; $display("FAIL r4_in_ready got %b want 1", in_ready_4); end
        want = tb_enc(16'h6F6B, 16'hA73B, 4);
        @(posedge clk); #1;
        in_valid_4 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid_4) begin lat = c; break; end
        end
        checks++; if (lat != 4) begin errors++; $display("FAIL r4_latency got %0d want 4", lat); end
        checks++; if (data_out_4 !== want) begin errors++; $display("FAIL r4_data got %h want %h", data_out_4, want); end
        tick();
        for (int i = 0; i < 200; i++) begin
            pt[i] = 16'($urandom);
            kk[i] = 16'($urandom);
        end
        run_stream4(1'b0);
        run_stream4(1'b1);
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_run_ignores_inputs();
        test_rounds4_random();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
